instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the RV32I core. Holds the program counter, drives the word address into the combinational instruction memory, and captures each returned instruction word together with its PC into a small in-order buffer. It presents the buffered entries to the decode stage over a valid/ready handshake and restarts fetch at a new target when the execute stage signals a redirect (branch or jump).

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned
- DEPTH, 2, fetch buffer entries; power of two, >= 2

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_addr  out  32  fetch address to instruction memory; always equals current PC
- imem_rdata  in  32  instruction word returned combinationally for imem_addr
- redirect_valid  in  1  single-cycle request to restart fetch at redirect_pc
- redirect_pc  in  32  redirect target byte address
- if_valid  out  1  buffer head holds a valid instruction
- if_ready  in  1  decode accepts head this cycle
- if_pc  out  32  PC of head entry; 0 when empty
- if_instr  out  32  instruction of head entry; 0 when empty
- fetch_misaligned  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: pc register, DEPTH-entry circular buffer of {pc, instr}, read/write pointers, count (clog2(DEPTH)+1 bits), FSM {RUN, HALT}.
- imem_addr = pc combinationally in every state.
- Pop: if_valid && if_ready; head advances.
- Push (RUN only, no redirect): when count < DEPTH, or count == DEPTH with a pop in the same cycle. Writes {pc, imem_rdata} at tail; pc <= pc + 4.
- Simultaneous push and pop: count unchanged; both pointers advance.
- No push: pc holds; imem_addr stable.
- Redirect (highest priority): buffer flushed (count, pointers to 0), pc <= redirect_pc, no push that cycle; a concurrent pop is treated as consumed and irrelevant.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0.
- HALT: no pushes, pops still drain remaining entries, redirects ignored; exit only via reset.

## Timing
- Reset values: pc = RESET_PC, count = 0, pointers 0, state RUN, if_valid = 0, if_pc = 0, if_instr = 0, fetch_misaligned = 0.
- Reset takes priority over redirect and handshake.
- Fetch latency: PC presented in cycle N is visible on if_pc/if_instr in cycle N+1 (registered buffer).
- First instruction after reset deassertion: if_valid = 1 one cycle later.
- Redirect in cycle N: cycle N+1 if_valid = 0, imem_addr = target; cycle N+2 if_valid = 1 with if_pc = target.
- Sustained throughput: one instruction per cycle with if_ready held high.
- if_valid, if_pc, if_instr stay stable while if_valid && !if_ready.
- Reset mid-stream: all buffered entries discarded at that edge.

## Configuration
- IF_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 flushes the buffer, sets fetch_misaligned = 1, and enters HALT. pc is not updated.
- IF_MISALIGN_CHECK_EN undefined: redirect_pc[1:0] is forced to 2'b00, so the target is rounded down. fetch_misaligned is tied to 0 and HALT is unreachable.

## Test plan
- Reset, if_ready = 1, memory word i = 32'h1000_0000 + i -> if_valid rises 1 cycle after reset; if_pc 0, 4, 8, … on consecutive cycles; if_instr matches.
- if_ready = 0 for 5 cycles after first valid (DEPTH = 2) -> count saturates at 2, imem_addr holds 32'h8; release -> if_pc 0, 4, 8, C in order, no loss or duplicate.
- Buffer full, redirect_valid with redirect_pc = 32'h40 -> next cycle if_valid = 0; following cycle if_pc = 32'h40, if_instr = mem[16].
- Pop and push in the same cycle while full -> count stays 2, order preserved.
- redirect_pc = 32'h42 -> with IF_MISALIGN_CHECK_EN: fetch_misaligned = 1 next cycle, if_valid = 0 after drain, persists until reset. Without it: fetch resumes at 32'h40.
- RESET_PC = 32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction memory port, redirect input and decode handshake.
// Latency: none, wiring only.
// Backpressure: decode drives if_ready; fetch holds the head stable while it is low.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  // fetch stage side
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr
  );

  // memory / execute / decode side
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage; PC register, combinational imem address, DEPTH-entry in-order buffer.
// Latency: PC presented in cycle N appears at the buffer head in cycle N+1; redirect target at N+2.
// Backpressure: fetch stalls (pc holds) when the buffer is full and decode does not pop.
// Optional macro IF_MISALIGN_CHECK_EN: a misaligned redirect halts fetch and sets fetch_misaligned;
// without it the redirect target is rounded down to a word boundary.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus,
  output logic          fetch_misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state, state_next;
  logic [31:0]     pc;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     fb_pc    [DEPTH];
  logic [31:0]     fb_instr [DEPTH];

  logic            pop;
  logic            push;
  logic            redirect_take;
  logic            redirect_bad;
  logic [31:0]     redirect_target;

  // the memory always sees the live PC, stalled or not
  assign bus.imem_addr = pc;
  assign bus.if_valid  = (count != '0);
  assign bus.if_pc     = bus.if_valid ? fb_pc[rd_ptr]    : 32'h0;
  assign bus.if_instr  = bus.if_valid ? fb_instr[rd_ptr] : 32'h0;

  // handshake, redirect qualification and push decision
  always_comb begin
    pop           = bus.if_valid && bus.if_ready;
    redirect_take = bus.redirect_valid && (state == RUN);
`ifdef IF_MISALIGN_CHECK_EN
    redirect_bad    = redirect_take && (bus.redirect_pc[1:0] != 2'b00);
    redirect_target = bus.redirect_pc;
`else
    redirect_bad    = 1'b0;
    redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
`endif
    // a full buffer may still accept a word when the head leaves in the same cycle
    push = (state == RUN) && !redirect_take && ((count < DEPTH_C) || pop);
  end

  // next-state: a bad redirect parks fetch until reset
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (redirect_bad) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // pc, pointers and occupancy; redirect flushes and wins over the handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_take) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (!redirect_bad) pc <= redirect_target;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        pc     <= pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // buffer storage; contents are only meaningful below count, so no reset needed
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fb_pc[wr_ptr]    <= pc;
      fb_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  logic misaligned_q;

  // sticky until reset
  always_ff @(posedge clk) begin
    if (reset)             misaligned_q <= 1'b0;
    else if (redirect_bad) misaligned_q <= 1'b1;
  end

  assign fetch_misaligned = misaligned_q;
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (RESET_PC 0 and FFFF_FFF8), scoreboard of accepted entries.
// Latency: n/a.
// Backpressure: if_ready driven directly by the stimulus.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic mis_a, mis_b;
  int   total = 0;
  int   bad   = 0;
  ent_t qa[$];
  ent_t qb[$];

  always #5 clk = ~clk;

  instr_fetch_if ifa();
  instr_fetch_if ifb();

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa), .fetch_misaligned(mis_a)
  );
  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb), .fetch_misaligned(mis_b)
  );

  // memory word i holds 32'h1000_0000 + i
  assign ifa.imem_rdata = 32'h1000_0000 + (ifa.imem_addr >> 2);
  assign ifb.imem_rdata = 32'h1000_0000 + (ifb.imem_addr >> 2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ea(input logic [31:0] p, input logic [31:0] i);
    qa.push_back({p, i});
  endtask

  task automatic eb(input logic [31:0] p, input logic [31:0] i);
    qb.push_back({p, i});
  endtask

  // monitor A: every accepted head must match the next expected entry
  always @(negedge clk) begin
    ent_t e;
    if (!rst_a && ifa.if_valid && ifa.if_ready) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected actual pc=%h required=none", ifa.if_pc);
      end else begin
        e = qa.pop_front();
        check("a_pc", ifa.if_pc, e.pc);
        check("a_instr", ifa.if_instr, e.instr);
      end
    end
  end

  // monitor B
  always @(negedge clk) begin
    ent_t e;
    if (!rst_b && ifb.if_valid && ifb.if_ready) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected actual pc=%h required=none", ifb.if_pc);
      end else begin
        e = qb.pop_front();
        check("b_pc", ifb.if_pc, e.pc);
        check("b_instr", ifb.if_instr, e.instr);
      end
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.if_ready = 1'b0; ifa.redirect_valid = 1'b0; ifa.redirect_pc = 32'h0;
    ifb.if_ready = 1'b0; ifb.redirect_valid = 1'b0; ifb.redirect_pc = 32'h0;
    repeat (3) tick();

    // reset state
    @(negedge clk);
    check("rst_valid", 32'(ifa.if_valid), 32'h0);
    check("rst_pc", ifa.if_pc, 32'h0);
    check("rst_instr", ifa.if_instr, 32'h0);
    check("rst_addr", ifa.imem_addr, 32'h0);
    check("rst_mis", 32'(mis_a), 32'h0);

    // release reset with decode stalled; buffer fills to 2, pc parks at 8
    tick();
    rst_a = 1'b0;
    @(negedge clk);
    check("first_valid_low", 32'(ifa.if_valid), 32'h0);
    tick();
    @(negedge clk);
    check("first_valid", 32'(ifa.if_valid), 32'h1);
    check("first_pc", ifa.if_pc, 32'h0);
    check("first_instr", ifa.if_instr, 32'h1000_0000);
    repeat (4) tick();
    @(negedge clk);
    check("stall_addr", ifa.imem_addr, 32'h8);
    check("stall_pc", ifa.if_pc, 32'h0);
    check("stall_valid", 32'(ifa.if_valid), 32'h1);

    // release: 0,4,8,C in order, one per cycle
    ea(32'h0, 32'h1000_0000);
    ea(32'h4, 32'h1000_0001);
    ea(32'h8, 32'h1000_0002);
    ea(32'hC, 32'h1000_0003);
    tick();
    ifa.if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream_valid", 32'(ifa.if_valid), 32'h1);
      tick();
    end
    ifa.if_ready = 1'b0;
    @(negedge clk);
    check("full_head", ifa.if_pc, 32'h10);
    check("full_addr", ifa.imem_addr, 32'h18);

    // redirect from a full buffer
    tick();
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc = 32'h40;
    tick();
    ifa.redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_valid_low", 32'(ifa.if_valid), 32'h0);
    check("redir_addr", ifa.imem_addr, 32'h40);
    tick();
    @(negedge clk);
    check("redir_valid", 32'(ifa.if_valid), 32'h1);
    check("redir_pc", ifa.if_pc, 32'h40);
    check("redir_instr", ifa.if_instr, 32'h1000_0010);
    ea(32'h40, 32'h1000_0010);
    ea(32'h44, 32'h1000_0011);
    ea(32'h48, 32'h1000_0012);
    tick();
    ifa.if_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tick();
    end
    ifa.if_ready = 1'b0;
    tick();

    // misaligned redirect target 0x42
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc = 32'h42;
    tick();
    ifa.redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    @(negedge clk);
    check("mis_flag", 32'(mis_a), 32'h1);
    check("mis_valid", 32'(ifa.if_valid), 32'h0);
    tick();
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc = 32'h80;
    ifa.if_ready = 1'b1;
    tick();
    ifa.redirect_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("halt_flag", 32'(mis_a), 32'h1);
    check("halt_valid", 32'(ifa.if_valid), 32'h0);
    check("halt_addr", ifa.imem_addr, 32'h54);
    ifa.if_ready = 1'b0;
`else
    @(negedge clk);
    check("mis_flag", 32'(mis_a), 32'h0);
    check("mis_valid", 32'(ifa.if_valid), 32'h0);
    check("mis_addr", ifa.imem_addr, 32'h40);
    tick();
    @(negedge clk);
    check("mis_resume_pc", ifa.if_pc, 32'h40);
    check("mis_resume_instr", ifa.if_instr, 32'h1000_0010);
    ea(32'h40, 32'h1000_0010);
    ifa.if_ready = 1'b1;
    tick();
    ifa.if_ready = 1'b0;
    tick();
`endif

    // reset mid-stream discards everything
    rst_a = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_valid", 32'(ifa.if_valid), 32'h0);
    check("mid_rst_pc", ifa.if_pc, 32'h0);
    check("mid_rst_addr", ifa.imem_addr, 32'h0);
    check("mid_rst_mis", 32'(mis_a), 32'h0);
    tick();
    rst_a = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_pc", ifa.if_pc, 32'h0);
    check("post_rst_valid", 32'(ifa.if_valid), 32'h1);

    // PC wrap on the second instance
    eb(32'hFFFF_FFF8, 32'h4FFF_FFFE);
    eb(32'hFFFF_FFFC, 32'h4FFF_FFFF);
    eb(32'h0000_0000, 32'h1000_0000);
    eb(32'h0000_0004, 32'h1000_0001);
    tick();
    rst_b = 1'b0;
    ifb.if_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tick();
    end
    ifb.if_ready = 1'b0;
    tick();

    check("qa_drained", 32'(qa.size()), 32'h0);
    check("qb_drained", 32'(qb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
